// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU for the EX stage of the multi-cycle CPU.
// Single-cycle ops complete on the accepting edge. MUL (shift-add) and DIVU
// (restoring) each take one bit per cycle for WIDTH cycles under Start/Done.
// The mul/div engine shares one pair of shift registers: hiQ/loQ hold the
// running high/low product for MUL, or the remainder/quotient for DIVU.

module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [3:0]               ALUop,
  input  logic [WIDTH-1:0]         ReadData1,
  input  logic [WIDTH-1:0]         ReadData2,
  input  logic [WIDTH-1:0]         Ext,
  input  logic [$clog2(WIDTH)-1:0] Sa,
  input  logic                     ALUSrcA,
  input  logic                     ALUSrcB,
  output logic                     Busy,
  output logic                     Done,
  output logic [WIDTH-1:0]         Result,
  output logic [WIDTH-1:0]         ResultHi,
  output logic                     Zero,
  output logic                     DivZero
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_XNOR = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateQ, stateD;
  logic [SHW-1:0]   cntQ, cntD;
  logic [WIDTH-1:0] hiQ, hiD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] opndQ, opndD;
  logic             isMulQ, isMulD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic [WIDTH-1:0] resultHiQ, resultHiD;
  logic             divZeroQ, divZeroD;

  logic [WIDTH-1:0] inA, inB;
  logic [WIDTH-1:0] singleRes;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi, mulLo;
  logic [WIDTH:0]   divShift;
  logic             divOk;
  logic [WIDTH-1:0] divHi, divLo;

  assign inA = ALUSrcA ? {{(WIDTH-SHW){1'b0}}, Sa} : ReadData1;
  assign inB = ALUSrcB ? Ext : ReadData2;

  // Result of every single-cycle op, computed from the live operand muxes
  always_comb begin
    singleRes = '0;
    case (ALUop)
      OP_ADD:  singleRes = inA + inB;
      OP_SUB:  singleRes = inA - inB;
      OP_SLL:  singleRes = inB << inA[SHW-1:0];
      OP_OR:   singleRes = inA | inB;
      OP_AND:  singleRes = inA & inB;
      OP_SLTU: singleRes = {{(WIDTH-1){1'b0}}, (inA < inB)};
      OP_SLT:  singleRes = {{(WIDTH-1){1'b0}}, ($signed(inA) < $signed(inB))};
      OP_XNOR: singleRes = ~(inA ^ inB);
      OP_SRL:  singleRes = inB >> inA[SHW-1:0];
      OP_SRA:  singleRes = $unsigned($signed(inB) >>> inA[SHW-1:0]);
      default: singleRes = '0;
    endcase
  end

  // One shift-add multiply step and one restoring divide step on hiQ/loQ
  always_comb begin
    mulSum   = {1'b0, hiQ} + (loQ[0] ? {1'b0, opndQ} : '0);
    mulHi    = mulSum[WIDTH:1];
    mulLo    = {mulSum[0], loQ[WIDTH-1:1]};
    divShift = {hiQ, loQ[WIDTH-1]};
    divOk    = (divShift >= {1'b0, opndQ});
    divHi    = divOk ? (divShift[WIDTH-1:0] - opndQ) : divShift[WIDTH-1:0];
    divLo    = {loQ[WIDTH-2:0], divOk};
  end

  // Next-state logic: launch from IDLE/DONE, iterate in ITER, publish results entering DONE
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    hiD       = hiQ;
    loD       = loQ;
    opndD     = opndQ;
    isMulD    = isMulQ;
    resultD   = resultQ;
    resultHiD = resultHiQ;
    divZeroD  = divZeroQ;
    case (stateQ)
      ITER: begin
        hiD  = isMulQ ? mulHi : divHi;
        loD  = isMulQ ? mulLo : divLo;
        cntD = cntQ + SHW'(1);
        if (cntQ == SHW'(WIDTH - 1)) begin
          stateD    = DONE;
          cntD      = '0;
          resultD   = isMulQ ? mulLo : divLo;
          resultHiD = isMulQ ? mulHi : divHi;
        end
      end
      IDLE, DONE: begin
        stateD = IDLE;
        if (Start) begin
          divZeroD = 1'b0;
          if (ALUop == OP_MUL) begin
            stateD = ITER;
            cntD   = '0;
            hiD    = '0;
            loD    = inB;
            opndD  = inA;
            isMulD = 1'b1;
          end else if (ALUop == OP_DIVU) begin
            if (inB == '0) begin
              stateD    = DONE;
              resultD   = '1;
              resultHiD = inA;
              divZeroD  = 1'b1;
            end else begin
              stateD = ITER;
              cntD   = '0;
              hiD    = '0;
              loD    = inA;
              opndD  = inB;
              isMulD = 1'b0;
            end
          end else begin
            stateD    = DONE;
            resultD   = singleRes;
            resultHiD = '0;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stateQ    <= IDLE;
      cntQ      <= '0;
      hiQ       <= '0;
      loQ       <= '0;
      opndQ     <= '0;
      isMulQ    <= 1'b0;
      resultQ   <= '0;
      resultHiQ <= '0;
      divZeroQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      hiQ       <= hiD;
      loQ       <= loD;
      opndQ     <= opndD;
      isMulQ    <= isMulD;
      resultQ   <= resultD;
      resultHiQ <= resultHiD;
      divZeroQ  <= divZeroD;
    end
  end

  assign Busy     = (stateQ == ITER);
  assign Done     = (stateQ == DONE);
  assign Result   = resultQ;
  assign ResultHi = resultHiQ;
  assign Zero     = (resultQ == '0);
  assign DivZero  = divZeroQ;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed and randomized checks of alu_iter against a
// latency/arithmetic reference model kept in the bench.

module tb_alu_iter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [3:0]  ALUop = '0;
  logic [31:0] ReadData1 = '0;
  logic [31:0] ReadData2 = '0;
  logic [31:0] Ext = '0;
  logic [4:0]  Sa = '0;
  logic        ALUSrcA = 1'b0;
  logic        ALUSrcB = 1'b0;
  logic        Busy, Done, Zero, DivZero;
  logic [31:0] Result, ResultHi;

  int total = 0;
  int bad = 0;

  alu_iter #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .ALUop(ALUop),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Ext(Ext), .Sa(Sa),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .Busy(Busy), .Done(Done), .Result(Result), .ResultHi(ResultHi),
    .Zero(Zero), .DivZero(DivZero)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op table
  function automatic void refOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [31:0] h,
                                output bit dz, output bit iter);
    logic [63:0] p;
    r = '0; h = '0; dz = 1'b0; iter = 1'b0; p = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = b << a[4:0];
      4'd3:  r = a | b;
      4'd4:  r = a & b;
      4'd5:  r = (a < b) ? 32'd1 : 32'd0;
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = ~(a ^ b);
      4'd8:  r = b >> a[4:0];
      4'd9:  r = $signed(b) >>> a[4:0];
      4'd10: begin p = 64'(a) * 64'(b); r = p[31:0]; h = p[63:32]; iter = 1'b1; end
      4'd11: begin
        if (b == 32'd0) begin r = '1; h = a; dz = 1'b1; end
        else begin r = a / b; h = a % b; iter = 1'b1; end
      end
      default: r = '0;
    endcase
  endfunction

  int          mLeft = 0;
  bit          mDone = 1'b0;
  logic [31:0] mRes = '0, mHi = '0, pRes = '0, pHi = '0;
  bit          mDz = 1'b0;

  // Model: accept when not busy, complete after 1 edge or 1+32 edges
  always @(posedge CLK or posedge Reset) begin
    logic [31:0] a, b, r, h;
    bit dz, it;
    if (Reset) begin
      mLeft = 0; mDone = 1'b0; mRes = '0; mHi = '0; mDz = 1'b0;
    end else if (mLeft > 0) begin
      mLeft--;
      mDone = 1'b0;
      if (mLeft == 0) begin
        mDone = 1'b1; mRes = pRes; mHi = pHi;
      end
    end else begin
      mDone = 1'b0;
      if (Start) begin
        a = ALUSrcA ? {27'd0, Sa} : ReadData1;
        b = ALUSrcB ? Ext : ReadData2;
        refOp(ALUop, a, b, r, h, dz, it);
        mDz = dz;
        if (it) begin
          mLeft = 32; pRes = r; pHi = h;
        end else begin
          mDone = 1'b1; mRes = r; mHi = h;
        end
      end
    end
  end

  // Compare DUT against the model every cycle on the falling edge
  always @(negedge CLK) begin
    checkOutput("busy", {31'd0, Busy}, {31'd0, (mLeft > 0)});
    checkOutput("done", {31'd0, Done}, {31'd0, mDone});
    checkOutput("result", Result, mRes);
    checkOutput("resultHi", ResultHi, mHi);
    checkOutput("zero", {31'd0, Zero}, {31'd0, (mRes == 32'd0)});
    if (mLeft == 0) checkOutput("divZero", {31'd0, DivZero}, {31'd0, mDz});
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] ext, input logic [4:0] sa,
                               input bit srcA, input bit srcB);
    ALUop = op; ReadData1 = rd1; ReadData2 = rd2; Ext = ext; Sa = sa;
    ALUSrcA = srcA; ALUSrcB = srcB; Start = 1'b1;
  endtask

  task automatic runOp(input string nm, input logic [3:0] op, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] ext, input logic [4:0] sa,
                       input bit srcA, input bit srcB, input int pulseAt,
                       output int lat, output int busyCnt);
    applyStimulus(op, rd1, rd2, ext, sa, srcA, srcB);
    lat = 0; busyCnt = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 1) begin Start = 1'b0; ReadData2 = $urandom; ReadData1 = $urandom; end
      if (pulseAt > 0 && lat == pulseAt) begin Start = 1'b1; ALUop = 4'd0; end
      if (pulseAt > 0 && lat == pulseAt + 1) Start = 1'b0;
      if (Busy) busyCnt++;
    end while (!Done && lat < 100);
    if (!Done) begin
      total++; bad++;
      $display("[TB] FAIL %s timeout: no Done within %0d edges", nm, lat);
    end
  endtask

  initial begin
    int lat, bc, doneSeen;
    repeat (2) @(posedge CLK);
    #2 Reset = 1'b0;
    #1;
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset done", {31'd0, Done}, 32'd0);
    checkOutput("reset result", Result, 32'd0);
    checkOutput("reset resultHi", ResultHi, 32'd0);
    checkOutput("reset zero", {31'd0, Zero}, 32'd1);
    checkOutput("reset divZero", {31'd0, DivZero}, 32'd0);
    @(posedge CLK); #1;

    runOp("add", 4'd0, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 0, lat, bc);
    checkOutput("add lat", lat, 32'd1);
    checkOutput("add result", Result, 32'd12);
    checkOutput("add zero", {31'd0, Zero}, 32'd0);

    runOp("sub", 4'd1, 32'd3, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 0, lat, bc);
    checkOutput("sub result", Result, 32'd0);
    checkOutput("sub zero", {31'd0, Zero}, 32'd1);

    runOp("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 0, lat, bc);
    checkOutput("slt result", Result, 32'd1);
    runOp("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 1'b0, 1'b0, 0, lat, bc);
    checkOutput("sltu result", Result, 32'd0);

    runOp("sra", 4'd9, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1'b0, 0, lat, bc);
    checkOutput("sra result", Result, 32'hF800_0000);
    runOp("srl", 4'd8, 32'd0, 32'h8000_0000, 32'd0, 5'd4, 1'b1, 1'b0, 0, lat, bc);
    checkOutput("srl result", Result, 32'h0800_0000);

    runOp("mul", 4'd10, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 10, lat, bc);
    checkOutput("mul lat", lat, 32'd33);
    checkOutput("mul busy cycles", bc, 32'd32);
    checkOutput("mul resultHi", ResultHi, 32'd1);
    checkOutput("mul result", Result, 32'hFFFF_FFFE);

    runOp("divu", 4'd11, 32'd100, 32'd0, 32'd7, 5'd0, 1'b0, 1'b1, 0, lat, bc);
    checkOutput("divu lat", lat, 32'd33);
    checkOutput("divu result", Result, 32'd14);
    checkOutput("divu resultHi", ResultHi, 32'd2);
    checkOutput("divu divZero", {31'd0, DivZero}, 32'd0);

    runOp("div0", 4'd11, 32'd9, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 0, lat, bc);
    checkOutput("div0 lat", lat, 32'd1);
    checkOutput("div0 result", Result, 32'hFFFF_FFFF);
    checkOutput("div0 resultHi", ResultHi, 32'd9);
    checkOutput("div0 divZero", {31'd0, DivZero}, 32'd1);

    @(posedge CLK); #1;
    applyStimulus(4'd10, 32'd1234, 32'd5678, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge CLK); #1 Start = 1'b0;
    repeat (9) @(posedge CLK);
    #2 Reset = 1'b1;
    #1;
    checkOutput("abort busy", {31'd0, Busy}, 32'd0);
    checkOutput("abort done", {31'd0, Done}, 32'd0);
    checkOutput("abort result", Result, 32'd0);
    @(posedge CLK); #2 Reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (Done) doneSeen++;
    end
    checkOutput("abort no done", doneSeen, 32'd0);
    runOp("add after abort", 4'd0, 32'd20, 32'd0, 32'd22, 5'd0, 1'b0, 1'b1, 0, lat, bc);
    checkOutput("add after abort lat", lat, 32'd1);
    checkOutput("add after abort result", Result, 32'd42);

    for (int c = 0; c < 4000; c++) begin
      @(posedge CLK); #1;
      Start = ($urandom_range(0, 2) == 0);
      ALUop = 4'($urandom_range(0, 15));
      ReadData1 = $urandom;
      ReadData2 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      Ext = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(0, 300));
      Sa = 5'($urandom_range(0, 31));
      ALUSrcA = ($urandom_range(0, 3) == 0);
      ALUSrcB = ($urandom_range(0, 1) == 0);
    end
    Start = 1'b0;
    repeat (40) @(posedge CLK);
    @(negedge CLK); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
